// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial systolic multiplier sequencer.
// State encoding is fixed so it can be matched against waveform captures.
package systolic_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One serial bit per product bit, plus the array pipeline delay.
    function automatic int stream_len(input int word_width, input int array_latency);
        return 2 * word_width + array_latency;
    endfunction

    function automatic int cnt_width(input int word_width, input int flush_cycles,
                                     input int array_latency);
        return clog2(max_int(flush_cycles, stream_len(word_width, array_latency)) + 1);
    endfunction

endpackage

// File: rtl/serial_deserializer.sv
// Right-shift capture register: serial bits enter at the MSB end, so after
// p_WIDTH shifts the first bit received sits at bit 0.
module serial_deserializer #(
    parameter int p_WIDTH = 8
) (
    input  logic               i_CLK,
    input  logic               i_RST_N,
    input  logic               i_CLEAR,
    input  logic               i_SHIFT_EN,
    input  logic               i_BIT,
    output logic [p_WIDTH-1:0] o_DATA
);

    logic [p_WIDTH-1:0] data_q;
    logic [p_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_CLEAR) begin
            data_d = '0;
        end else if (i_SHIFT_EN) begin
            data_d = {i_BIT, data_q[p_WIDTH-1:1]};
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_DATA = data_q;

endmodule

// File: rtl/systolic_mult_ctrl.sv
// Sequencer for a bit-serial systolic multiplier: accept operands, flush the
// array carries, stream the multiplicand LSB-first, and collect the 2N-bit product.
module systolic_mult_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int p_WORD_WIDTH    = 4,
    parameter int p_ARRAY_LATENCY = 1,
    parameter int p_FLUSH_CYCLES  = 8
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_N,
    input  logic                      i_START_VALID,
    output logic                      o_START_READY,
    input  logic [p_WORD_WIDTH-1:0]   i_MULTIPLIER,
    input  logic [p_WORD_WIDTH-1:0]   i_MULTIPLICAND,
    output logic [p_WORD_WIDTH-1:0]   o_ARR_MULTIPLIER,
    output logic                      o_ARR_MULTIPLICAND,
    input  logic                      i_ARR_OUTPUT,
    output logic                      o_RESULT_VALID,
    input  logic                      i_RESULT_READY,
    output logic [2*p_WORD_WIDTH-1:0] o_RESULT,
    output logic                      o_BUSY
);

    localparam int N          = p_WORD_WIDTH;
    localparam int STREAM_LEN = stream_len(N, p_ARRAY_LATENCY);
    localparam int CNT_W      = cnt_width(N, p_FLUSH_CYCLES, p_ARRAY_LATENCY);

    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'((p_FLUSH_CYCLES > 0) ? p_FLUSH_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] LAT_CNT     = CNT_W'(p_ARRAY_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [N-1:0]     BIT_ONE     = N'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       mplier_q, mplier_d;
    logic [N-1:0]       mcand_q, mcand_d;
    logic               start_ready_q, start_ready_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic [N-1:0]       arr_mplier_q, arr_mplier_d;
    logic               arr_mcand_q, arr_mcand_d;
    logic               deser_clear;
    logic               deser_shift;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        deser_clear = 1'b0;
        deser_shift = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_START_VALID && start_ready_q) begin
                    mplier_d    = i_MULTIPLIER;
                    mcand_d     = i_MULTIPLICAND;
                    cnt_d       = '0;
                    deser_clear = 1'b1;
                    state_d     = (p_FLUSH_CYCLES == 0) ? STREAM : FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STREAM: begin
                // Product bit k-LAT appears at the array output on stream cycle k.
                deser_shift = (cnt_q >= LAT_CNT);
                if (cnt_q == STREAM_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (i_RESULT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line
        // up with the state and counter they describe.
        start_ready_d  = (state_d == IDLE);
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
        arr_mplier_d   = (state_d == STREAM) ? mplier_d : '0;
        // Counts at or beyond N select no bit, giving the zero padding for free.
        arr_mcand_d    = (state_d == STREAM) && (|(mcand_d & (BIT_ONE << cnt_d)));
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mplier_q       <= '0;
            mcand_q        <= '0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            arr_mplier_q   <= '0;
            arr_mcand_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mplier_q       <= mplier_d;
            mcand_q        <= mcand_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            arr_mplier_q   <= arr_mplier_d;
            arr_mcand_q    <= arr_mcand_d;
        end
    end

    serial_deserializer #(
        .p_WIDTH (2 * N)
    ) u_product (
        .i_CLK      (i_CLK),
        .i_RST_N    (i_RST_N),
        .i_CLEAR    (deser_clear),
        .i_SHIFT_EN (deser_shift),
        .i_BIT      (i_ARR_OUTPUT),
        .o_DATA     (o_RESULT)
    );

    assign o_START_READY      = start_ready_q;
    assign o_RESULT_VALID     = result_valid_q;
    assign o_BUSY             = busy_q;
    assign o_ARR_MULTIPLIER   = arr_mplier_q;
    assign o_ARR_MULTIPLICAND = arr_mcand_q;

endmodule

// File: tb/tb_systolic_mult_ctrl.sv
// Self-checking bench: two controllers (flush 8 and flush 0), each driving a
// behavioural serial-parallel array model, checked against plain arithmetic.
module tb_systolic_mult_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sv   [2];
    logic       sr   [2];
    logic [3:0] mp   [2];
    logic [3:0] mc   [2];
    logic [3:0] amp  [2];
    logic       amc  [2];
    logic       aout [2] = '{1'b0, 1'b0};
    logic       rv   [2];
    logic       rr   [2];
    logic [7:0] res  [2];
    logic       busy [2];
    logic [7:0] arr_s [2] = '{8'd0, 8'd0};

    int vectors;
    int miscompares;

    systolic_mult_ctrl #(.p_WORD_WIDTH(4), .p_ARRAY_LATENCY(1), .p_FLUSH_CYCLES(8)) dut (
        .i_CLK(clk), .i_RST_N(rst_n),
        .i_START_VALID(sv[0]), .o_START_READY(sr[0]),
        .i_MULTIPLIER(mp[0]), .i_MULTIPLICAND(mc[0]),
        .o_ARR_MULTIPLIER(amp[0]), .o_ARR_MULTIPLICAND(amc[0]), .i_ARR_OUTPUT(aout[0]),
        .o_RESULT_VALID(rv[0]), .i_RESULT_READY(rr[0]), .o_RESULT(res[0]), .o_BUSY(busy[0])
    );

    systolic_mult_ctrl #(.p_WORD_WIDTH(4), .p_ARRAY_LATENCY(1), .p_FLUSH_CYCLES(0)) dut_nf (
        .i_CLK(clk), .i_RST_N(rst_n),
        .i_START_VALID(sv[1]), .o_START_READY(sr[1]),
        .i_MULTIPLIER(mp[1]), .i_MULTIPLICAND(mc[1]),
        .o_ARR_MULTIPLIER(amp[1]), .o_ARR_MULTIPLICAND(amc[1]), .i_ARR_OUTPUT(aout[1]),
        .o_RESULT_VALID(rv[1]), .i_RESULT_READY(rr[1]), .o_RESULT(res[1]), .o_BUSY(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial-parallel array: carry state S absorbs multiplier*bit each cycle,
    // emits its LSB one cycle later and shifts right. Not reset by rst_n.
    function automatic logic [7:0] arr_sum(input logic [7:0] s, input logic [3:0] m, input logic b);
        return s + (b ? {4'b0, m} : 8'd0);
    endfunction

    function automatic logic lsb(input logic [7:0] v);
        return v[0];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            aout[i]  <= lsb(arr_sum(arr_s[i], amp[i], amc[i]));
            arr_s[i] <= arr_sum(arr_s[i], amp[i], amc[i]) >> 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation on controller d, with optional result back-pressure
    // and an optional start request injected while the array is streaming.
    task automatic run_op(input int d, input logic [3:0] a, input logic [3:0] b,
                          input int hold, input bit inject, output logic [7:0] got);
        int         flush;
        int         n;
        int         k;
        int         mp_bad;
        int         rdy_bad;
        int         stall_bad;
        logic [8:0] mc_seen;
        logic [7:0] expect_p;

        flush     = (d == 0) ? 8 : 0;
        expect_p  = {4'b0, a} * {4'b0, b};
        mp_bad    = 0;
        rdy_bad   = 0;
        stall_bad = 0;
        mc_seen   = '0;

        for (int w = 0; w < 50 && !sr[d]; w++) @(negedge clk);
        check("start_ready_before_op", sr[d], 1);

        sv[d] = 1'b1;
        mp[d] = a;
        mc[d] = b;
        @(negedge clk);
        n     = 1;
        sv[d] = 1'b0;
        mp[d] = 4'($urandom);
        mc[d] = 4'($urandom);

        while (n < 100 && !rv[d]) begin
            if (sr[d] !== 1'b0 || busy[d] !== 1'b1) rdy_bad++;
            if (n > flush && n <= flush + 9) begin
                k = n - flush - 1;
                if (amp[d] !== a) mp_bad++;
                mc_seen[k] = amc[d];
            end else if (amp[d] !== 4'd0 || amc[d] !== 1'b0) begin
                mp_bad++;
            end
            if (inject && n == flush + 3) begin
                sv[d] = 1'b1;
                mp[d] = 4'd3;
                mc[d] = 4'd3;
            end
            if (inject && n == flush + 6) sv[d] = 1'b0;
            @(negedge clk);
            n++;
        end

        check("latency_cycles", n, 1 + flush + 8 + 1);
        check("mcand_serial_stream", mc_seen, {5'b0, b});
        check("arr_inputs_gated", mp_bad, 0);
        check("ready_busy_during_op", rdy_bad, 0);
        check("done_arr_inputs_zero", {amp[d], amc[d]}, 0);
        got = res[d];
        check("product", res[d], expect_p);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res[d] !== expect_p || rv[d] !== 1'b1 || sr[d] !== 1'b0 || busy[d] !== 1'b1)
                stall_bad++;
        end
        check("stall_stable", stall_bad, 0);

        rr[d] = 1'b1;
        @(negedge clk);
        rr[d] = 1'b0;
        check("valid_dropped", rv[d], 0);
        check("idle_start_ready", sr[d], 1);
        check("idle_busy_low", busy[d], 0);
        check("idle_holds_result", res[d], expect_p);
    endtask

    initial begin
        logic [7:0] got;
        logic [3:0] ra;
        logic [3:0] rb;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0;
            mp[i] = '0;
            mc[i] = '0;
            rr[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("reset_start_ready", sr[0], 1);
        check("reset_result_valid", rv[0], 0);
        check("reset_busy", busy[0], 0);
        check("reset_arr_mplier", amp[0], 0);
        check("reset_arr_mcand", amc[0], 0);
        check("reset_result", res[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 4'd13, 4'd11, 0, 1'b0, got);
        check("basic_13x11", got, 8'h8F);
        run_op(0, 4'd15, 4'd15, 20, 1'b0, got);
        check("max_15x15", got, 8'hE1);
        run_op(0, 4'd0, 4'd9, 1, 1'b0, got);
        check("zero_0x9", got, 8'h00);
        run_op(0, 4'd1, 4'd15, 2, 1'b0, got);
        check("one_1x15", got, 8'h0F);

        run_op(0, 4'd5, 4'd6, 0, 1'b1, got);
        check("busy_ignore_5x6", got, 8'h1E);
        repeat (3) @(negedge clk);
        check("no_second_op_busy", busy[0], 0);
        check("no_second_op_valid", rv[0], 0);

        // Abort on stream cycle k=3, leaving carries inside the array model.
        sv[0] = 1'b1;
        mp[0] = 4'd14;
        mc[0] = 4'd13;
        @(negedge clk);
        sv[0] = 1'b0;
        repeat (8 + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_start_ready", sr[0], 1);
        check("midrst_result_valid", rv[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_arr_mplier", amp[0], 0);
        check("midrst_arr_mcand", amc[0], 0);
        check("midrst_result", res[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 4'd7, 4'd9, 0, 1'b0, got);
        check("after_reset_7x9", got, 8'h3F);

        run_op(1, 4'd13, 4'd11, 0, 1'b0, got);
        check("noflush_13x11", got, 8'h8F);
        run_op(1, 4'd15, 4'd15, 3, 1'b0, got);
        check("noflush_15x15", got, 8'hE1);

        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(0, ra, rb, int'($urandom_range(0, 3)), 1'($urandom), got);
        end
        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(1, ra, rb, int'($urandom_range(0, 3)), 1'b0, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
